// File: rtl/pair_toggle_monitor.sv
// pair_toggle_monitor
//   Receive-side checker for a complementary-toggle pair (x, y). The pair is
//   healthy when x == y and both invert every clock. The block arms on the
//   first enabled edge, acquires lock after LOCK_CYCLES consecutive good
//   samples, counts bad samples while locked and latches a sticky fault after
//   MAX_ERR consecutive bad samples.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         monitor enable; 0 returns the block to IDLE
//   x_in/y_in  pair bits, synchronous to clk
//   clr_err    1-cycle pulse: clears err_cnt and leaves FAULT (goes to SYNC)
//   locked     1 while in LOCKED
//   err_flag   1 while in FAULT
//   mismatch   1-cycle pulse per bad sample judged in LOCKED
//   err_cnt    saturating count of bad samples judged in LOCKED
//   dbg_state  current FSM state (0 IDLE, 1 SYNC, 2 LOCKED, 3 FAULT)
//
// All outputs are registered: they reflect the sample taken at edge N right
// after edge N.
module pair_toggle_monitor #(
  parameter int ERR_CNT_W   = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int MAX_ERR     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 x_in,
  input  logic                 y_in,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err_flag,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  localparam int CNT_MAX = (LOCK_CYCLES > MAX_ERR) ? LOCK_CYCLES : MAX_ERR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter values on the edge that completes lock / forces fault.
  localparam logic [CNT_W-1:0]     LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]     ERR_LAST  = CNT_W'(MAX_ERR - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_SAT   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state;
  logic             prev_valid;
  logic             prev_x;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;
  logic             sample_good;

  // Good sample: the pair agrees and has inverted since the previous edge.
  assign sample_good = (x_in == y_in) && (x_in != prev_x);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_valid <= 1'b0;
      prev_x     <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      locked     <= 1'b0;
      err_flag   <= 1'b0;
      mismatch   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      mismatch <= 1'b0;

      // clr_err acts in every state, including when en is low.
      if (clr_err) begin
        err_cnt <= '0;
        bad_cnt <= '0;
      end

      if (!en) begin
        // en dominates: drop back to IDLE and forget the history.
        state      <= IDLE;
        prev_valid <= 1'b0;
        good_cnt   <= '0;
        bad_cnt    <= '0;
        locked     <= 1'b0;
        err_flag   <= 1'b0;
      end else begin
        prev_x     <= x_in;
        prev_valid <= 1'b1;

        if (!prev_valid) begin
          // Arming edge: only captures prev_x, no judgement.
          state    <= SYNC;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end else begin
          case (state)
            SYNC: begin
              if (sample_good) begin
                if (good_cnt == LOCK_LAST) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  good_cnt <= '0;
                end else begin
                  good_cnt <= good_cnt + CNT_W'(1);
                end
              end else begin
                good_cnt <= '0;
              end
            end

            LOCKED: begin
              // A same-edge clr_err discards the sample entirely.
              if (!clr_err) begin
                if (sample_good) begin
                  bad_cnt <= '0;
                end else begin
                  mismatch <= 1'b1;
                  if (err_cnt != ERR_SAT) err_cnt <= err_cnt + ERR_CNT_W'(1);
                  if (bad_cnt == ERR_LAST) begin
                    state    <= FAULT;
                    locked   <= 1'b0;
                    err_flag <= 1'b1;
                    bad_cnt  <= '0;
                  end else begin
                    bad_cnt <= bad_cnt + CNT_W'(1);
                  end
                end
              end
            end

            FAULT: begin
              if (clr_err) begin
                state    <= SYNC;
                err_flag <= 1'b0;
                good_cnt <= '0;
              end
            end

            default: begin
              state    <= SYNC;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pair_toggle_monitor.sv
// Testbench for pair_toggle_monitor. Two instances share the stimulus: the
// default configuration and one with a 2-bit error counter so saturation is
// reachable quickly. A behavioural model tracks the sample history and the
// outputs are compared every cycle; directed scenarios add literal checks.
module tb_pair_toggle_monitor;

  localparam int LOCK_CYCLES = 4;
  localparam int MAX_ERR     = 3;

  localparam int PH_IDLE   = 0;
  localparam int PH_SYNC   = 1;
  localparam int PH_LOCKED = 2;
  localparam int PH_FAULT  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst_n;
  logic       en;
  logic       x_in;
  logic       y_in;
  logic       clr_err;
  logic       locked,   err_flag,   mismatch;
  logic       locked2,  err_flag2,  mismatch2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [1:0] dbg_state, dbg_state2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pair_toggle_monitor #(.ERR_CNT_W(8), .LOCK_CYCLES(LOCK_CYCLES), .MAX_ERR(MAX_ERR)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x_in(x_in), .y_in(y_in), .clr_err(clr_err),
    .locked(locked), .err_flag(err_flag), .mismatch(mismatch), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  pair_toggle_monitor #(.ERR_CNT_W(2), .LOCK_CYCLES(LOCK_CYCLES), .MAX_ERR(MAX_ERR)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x_in(x_in), .y_in(y_in), .clr_err(clr_err),
    .locked(locked2), .err_flag(err_flag2), .mismatch(mismatch2), .err_cnt(err_cnt2),
    .dbg_state(dbg_state2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks phase, whether a previous sample exists, run lengths of good/bad
  // samples and the raw (unbounded) number of bad samples judged while locked
  // since the last clear. Saturating counts are derived with min().
  int m_phase;
  bit m_armed;
  bit m_prev;
  int m_good_run;
  int m_bad_run;
  int m_raw;
  bit m_mis;

  function automatic void model_reset();
    m_phase = PH_IDLE; m_armed = 0; m_prev = 0;
    m_good_run = 0; m_bad_run = 0; m_raw = 0; m_mis = 0;
  endfunction

  function automatic int sat(input int raw, input int w);
    int top;
    top = (1 << w) - 1;
    return (raw > top) ? top : raw;
  endfunction

  function automatic void model_step(input bit e, input bit x, input bit y, input bit c);
    bit good;
    good  = (x == y) && (x != m_prev);
    m_mis = 0;
    if (c) begin
      m_raw = 0;
      m_bad_run = 0;
    end
    if (!e) begin
      m_phase = PH_IDLE; m_armed = 0; m_good_run = 0; m_bad_run = 0;
      return;
    end
    if (!m_armed) begin
      m_armed = 1; m_prev = x; m_phase = PH_SYNC; m_good_run = 0; m_bad_run = 0;
      return;
    end
    m_prev = x;
    if (m_phase == PH_SYNC) begin
      m_good_run = good ? m_good_run + 1 : 0;
      if (m_good_run == LOCK_CYCLES) begin
        m_phase = PH_LOCKED;
        m_good_run = 0;
      end
    end else if (m_phase == PH_LOCKED) begin
      if (!c) begin
        if (good) m_bad_run = 0;
        else begin
          m_mis = 1;
          m_raw++;
          m_bad_run++;
          if (m_bad_run == MAX_ERR) begin
            m_phase = PH_FAULT;
            m_bad_run = 0;
          end
        end
      end
    end else if (m_phase == PH_FAULT) begin
      if (c) begin
        m_phase = PH_SYNC;
        m_good_run = 0;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  // Entry layout: {locked, err_flag, mismatch, err_cnt(8), err_cnt(2)}
  logic [12:0] exp_q[$];
  logic [12:0] cmp_e;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      model_step(en, x_in, y_in, clr_err);
      exp_q.push_back({m_phase == PH_LOCKED, m_phase == PH_FAULT, m_mis,
                       8'(sat(m_raw, 8)), 2'(sat(m_raw, 2))});
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      check("locked",      {31'd0, locked},    {31'd0, cmp_e[12]});
      check("err_flag",    {31'd0, err_flag},  {31'd0, cmp_e[11]});
      check("mismatch",    {31'd0, mismatch},  {31'd0, cmp_e[10]});
      check("err_cnt",     {24'd0, err_cnt},   {24'd0, cmp_e[9:2]});
      check("locked_w2",   {31'd0, locked2},   {31'd0, cmp_e[12]});
      check("err_flag_w2", {31'd0, err_flag2}, {31'd0, cmp_e[11]});
      check("mismatch_w2", {31'd0, mismatch2}, {31'd0, cmp_e[10]});
      check("err_cnt_w2",  {30'd0, err_cnt2},  {30'd0, cmp_e[1:0]});
    end
  end

  // ---------------- driver tasks ----------------
  bit px;  // last x driven

  task automatic cyc(input bit e, input bit x, input bit y, input bit c);
    @(negedge clk);
    en = e; x_in = x; y_in = y; clr_err = c;
    px = x;
    @(posedge clk);
    #1;
  endtask

  task automatic tog(input bit c);   // healthy toggle
    cyc(1'b1, !px, !px, c);
  endtask

  task automatic hold();             // no toggle: a bad sample
    cyc(1'b1, px, px, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"},   {31'd0, locked},   32'd0);
    check({tag, "_err_flag"}, {31'd0, err_flag}, 32'd0);
    check({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
    check({tag, "_err_cnt"},  {24'd0, err_cnt},  32'd0);
    check({tag, "_state"},    {30'd0, dbg_state}, 32'd0);
    check({tag, "_err_cnt_w2"}, {30'd0, err_cnt2}, 32'd0);
    check({tag, "_state_w2"},   {30'd0, dbg_state2}, 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    model_reset();
    exp_q.delete();
    en = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; x_in = 1'b0; y_in = 1'b0; clr_err = 1'b0; px = 1'b0;
    model_reset();
    #7 check_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock acquisition: arm, then four good samples.
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    lit("lock_not_yet", {31'd0, locked}, 32'd0);
    cyc(1, 0, 0, 0);
    lit("lock_after_5", {31'd0, locked}, 32'd1);
    lit("lock_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Single bad sample while locked.
    cyc(1, 1, 0, 0);
    lit("bad_mismatch", {31'd0, mismatch}, 32'd1);
    lit("bad_err_cnt",  {24'd0, err_cnt},  32'd1);
    lit("bad_locked",   {31'd0, locked},   32'd1);
    cyc(1, 0, 0, 0);
    lit("pulse_one_cycle", {31'd0, mismatch}, 32'd0);
    lit("bad_cnt_hold",    {24'd0, err_cnt},  32'd1);

    // Clear while locked at 11, then three stuck samples force FAULT.
    cyc(1, 1, 1, 1);
    lit("clr_locked_cnt", {24'd0, err_cnt}, 32'd0);
    lit("clr_locked_st",  {31'd0, locked},  32'd1);
    hold();
    hold();
    lit("stuck2_flag", {31'd0, err_flag}, 32'd0);
    hold();
    lit("fault_cnt",    {24'd0, err_cnt},  32'd3);
    lit("fault_flag",   {31'd0, err_flag}, 32'd1);
    lit("fault_locked", {31'd0, locked},   32'd0);

    // clr_err in FAULT with a bad sample on the same edge.
    cyc(1, 0, 1, 1);
    lit("clr_fault_cnt",  {24'd0, err_cnt},  32'd0);
    lit("clr_fault_flag", {31'd0, err_flag}, 32'd0);
    lit("clr_fault_mis",  {31'd0, mismatch}, 32'd0);
    lit("clr_fault_st",   {30'd0, dbg_state}, 32'd1);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    lit("relock_after_clr", {31'd0, locked}, 32'd1);

    // en low drops lock but holds err_cnt.
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    lit("en0_locked",  {31'd0, locked},  32'd0);
    lit("en0_err_cnt", {24'd0, err_cnt}, 32'd1);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    lit("en_relock_3", {31'd0, locked}, 32'd0);
    cyc(1, 1, 1, 0);
    lit("en_relock_4", {31'd0, locked}, 32'd1);

    // Mid-cycle reset while locked, then relock from scratch.
    do_reset("rst_locked");
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    lit("rst_relock_3", {31'd0, locked}, 32'd0);
    cyc(1, 0, 0, 0);
    lit("rst_relock_4", {31'd0, locked}, 32'd1);

    // Saturation of the 2-bit counter: isolated bad samples in LOCKED.
    tog(1'b1);
    for (int i = 0; i < 5; i++) begin
      hold();
      lit("sat_mismatch_w2", {31'd0, mismatch2}, 32'd1);
      tog(1'b0);
    end
    lit("sat_err_cnt_w2", {30'd0, err_cnt2}, 32'd3);
    lit("sat_err_cnt_w8", {24'd0, err_cnt},  32'd5);
    lit("sat_locked_w2",  {31'd0, locked2},  32'd1);

    // Randomized traffic: mostly healthy toggling with injected faults.
    for (int i = 0; i < 3000; i++) begin
      bit e, c, x, y;
      if ($urandom_range(0, 599) == 0) do_reset("rst_rand");
      e = ($urandom_range(0, 39) != 0);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) < 85) begin
        x = !px; y = !px;
      end else begin
        x = 1'($urandom_range(0, 1));
        y = 1'($urandom_range(0, 1));
      end
      cyc(e, x, y, c);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
